hpi_bus_sequencer: RTL and testbench



---
 rtl/hpi_bus_sequencer_if.sv | 32 +++
 rtl/hpi_bus_sequencer.sv | 135 +++++++++++++
 tb/tb_hpi_bus_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hpi_bus_sequencer_if.sv
// Avalon-MM slave-side signal bundle for the HPI bus sequencer.
// Ports: address/chipselect/read/write/writedata flow master->slave,
//        readdata/waitrequest flow slave->master.
interface hpi_bus_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport slave (
        input  address,
        input  chipselect,
        input  read,
        input  write,
        input  writedata,
        output readdata,
        output waitrequest
    );

    modport master (
        output address,
        output chipselect,
        output read,
        output write,
        output writedata,
        input  readdata,
        input  waitrequest
    );
endinterface

// File: rtl/hpi_bus_sequencer.sv
// Purpose: turns one Avalon-MM access into one timed CY7C67200 HPI bus cycle.
// Latency: waitrequest drops SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles after the request appears.
// Backpressure: waitrequest stalls the master until the DONE cycle; new accesses start only from IDLE.
//
// Ports: clk, reset_n (async active-low); av = Avalon slave (address, chipselect,
// read, write, writedata, readdata, waitrequest); hpi_* = registered HPI pad signals,
// hpi_data_in is the pad input sampled at the end of a read strobe.
module hpi_bus_sequencer #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    hpi_bus_sequencer_if.slave   av,
    output logic [1:0]           hpi_addr,
    output logic [15:0]          hpi_data_out,
    input  logic [15:0]          hpi_data_in,
    output logic                 hpi_data_oe,
    output logic                 hpi_cs_n,
    output logic                 hpi_rd_n,
    output logic                 hpi_wr_n
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_t;

    // The counter holds "cycles remaining minus one" so a phase of N clocks
    // loads N-1 and advances when it reaches zero.
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        is_write;
    logic [15:0] rd_capture;
    logic        request;

    // Only the low half of writedata reaches the 16-bit HPI data bus.
    logic        unused_wdata_hi;
    assign unused_wdata_hi = ^av.writedata[31:16];

    assign request = av.chipselect & (av.read | av.write);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            is_write     <= 1'b0;
            rd_capture   <= 16'd0;
            hpi_addr     <= 2'd0;
            hpi_data_out <= 16'd0;
            hpi_data_oe  <= 1'b0;
            hpi_cs_n     <= 1'b1;
            hpi_rd_n     <= 1'b1;
            hpi_wr_n     <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (request) begin
                        state        <= ST_SETUP;
                        cnt          <= SETUP_LD;
                        // write wins when read and write are both asserted
                        is_write     <= av.write;
                        hpi_addr     <= av.address;
                        hpi_data_out <= av.writedata[15:0];
                        hpi_cs_n     <= 1'b0;
                        hpi_data_oe  <= av.write;
                    end
                end

                ST_SETUP: begin
                    if (cnt == 4'd0) begin
                        state    <= ST_STROBE;
                        cnt      <= STROBE_LD;
                        hpi_rd_n <= is_write;
                        hpi_wr_n <= ~is_write;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                ST_STROBE: begin
                    if (cnt == 4'd0) begin
                        state    <= ST_HOLD;
                        cnt      <= HOLD_LD;
                        hpi_rd_n <= 1'b1;
                        hpi_wr_n <= 1'b1;
                        // sample the pad on the edge that closes the read strobe
                        if (!is_write) begin
                            rd_capture <= hpi_data_in;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                ST_HOLD: begin
                    if (cnt == 4'd0) begin
                        state       <= ST_DONE;
                        cnt         <= 4'd0;
                        hpi_cs_n    <= 1'b1;
                        hpi_data_oe <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                ST_DONE: begin
                    // a request still held here is the one just completed
                    state <= ST_IDLE;
                end

                default: begin
                    state       <= ST_IDLE;
                    cnt         <= 4'd0;
                    hpi_cs_n    <= 1'b1;
                    hpi_rd_n    <= 1'b1;
                    hpi_wr_n    <= 1'b1;
                    hpi_data_oe <= 1'b0;
                end
            endcase
        end
    end

    assign av.readdata    = {16'd0, rd_capture};
    assign av.waitrequest = request & (state != ST_DONE);

endmodule

// File: tb/tb_hpi_bus_sequencer.sv
module tb_hpi_bus_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    int ntests = 0;
    int nfail  = 0;

    // dut 0: default timing, dut 1: 1/1/1 timing
    function automatic int s_of(input int i); return (i == 0) ? 2 : 1; endfunction
    function automatic int t_of(input int i); return (i == 0) ? 4 : 1; endfunction
    function automatic int h_of(input int i); return (i == 0) ? 2 : 1; endfunction
    function automatic int tot(input int i); return s_of(i) + t_of(i) + h_of(i) + 1; endfunction

    logic [1:0]  t_addr [2];
    logic        t_cs   [2];
    logic        t_rd   [2];
    logic        t_wr   [2];
    logic [31:0] t_wd   [2];
    logic [15:0] t_din  [2];
    logic        din_rand = 1'b0;

    logic [1:0]  o_addr  [2];
    logic [15:0] o_dout  [2];
    logic        o_oe    [2];
    logic        o_cs    [2];
    logic        o_rdn   [2];
    logic        o_wrn   [2];
    logic [31:0] o_rdata [2];
    logic        o_wait  [2];

    hpi_bus_sequencer_if av0();
    hpi_bus_sequencer_if av1();

    assign av0.address    = t_addr[0];
    assign av0.chipselect = t_cs[0];
    assign av0.read       = t_rd[0];
    assign av0.write      = t_wr[0];
    assign av0.writedata  = t_wd[0];
    assign av1.address    = t_addr[1];
    assign av1.chipselect = t_cs[1];
    assign av1.read       = t_rd[1];
    assign av1.write      = t_wr[1];
    assign av1.writedata  = t_wd[1];
    assign o_rdata[0] = av0.readdata;
    assign o_wait[0]  = av0.waitrequest;
    assign o_rdata[1] = av1.readdata;
    assign o_wait[1]  = av1.waitrequest;

    hpi_bus_sequencer dut0 (
        .clk(clk), .reset_n(reset_n), .av(av0),
        .hpi_addr(o_addr[0]), .hpi_data_out(o_dout[0]), .hpi_data_in(t_din[0]),
        .hpi_data_oe(o_oe[0]), .hpi_cs_n(o_cs[0]), .hpi_rd_n(o_rdn[0]), .hpi_wr_n(o_wrn[0])
    );

    hpi_bus_sequencer #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .av(av1),
        .hpi_addr(o_addr[1]), .hpi_data_out(o_dout[1]), .hpi_data_in(t_din[1]),
        .hpi_data_oe(o_oe[1]), .hpi_cs_n(o_cs[1]), .hpi_rd_n(o_rdn[1]), .hpi_wr_n(o_wrn[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each access is a timeline indexed by cycles since acceptance.
    // m_off = 0 idle; 1..S setup; S+1..S+T strobe; ..S+T+H hold; S+T+H+1 done.
    int          m_off  [2] = '{0, 0};
    logic        m_wr   [2] = '{1'b0, 1'b0};
    logic [1:0]  m_addr [2] = '{2'd0, 2'd0};
    logic [15:0] m_dat  [2] = '{16'd0, 16'd0};
    logic [15:0] m_rd   [2] = '{16'd0, 16'd0};

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_off[i] = 0; m_wr[i] = 1'b0; m_addr[i] = 2'd0; m_dat[i] = 16'd0; m_rd[i] = 16'd0;
            end else if (m_off[i] == 0) begin
                if (t_cs[i] && (t_rd[i] || t_wr[i])) begin
                    m_off[i]  = 1;
                    m_wr[i]   = t_wr[i];
                    m_addr[i] = t_addr[i];
                    m_dat[i]  = t_wd[i][15:0];
                end
            end else if (m_off[i] == tot(i)) begin
                m_off[i] = 0;
            end else begin
                if (!m_wr[i] && m_off[i] == s_of(i) + t_of(i)) m_rd[i] = t_din[i];
                m_off[i] = m_off[i] + 1;
            end
        end
    end

    // cs_n high-run monitor: length of the last completed gap between HPI cycles
    int hi_run   [2] = '{0, 0};
    int last_gap [2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int  o, s, t, h;
            bit  act, strb, req;
            o    = m_off[i]; s = s_of(i); t = t_of(i); h = h_of(i);
            act  = (o >= 1) && (o <= s + t + h);
            strb = (o > s) && (o <= s + t);
            req  = t_cs[i] && (t_rd[i] || t_wr[i]);
            chk($sformatf("dut%0d cs_n", i),  32'(o_cs[i]),  32'(!act));
            chk($sformatf("dut%0d rd_n", i),  32'(o_rdn[i]), 32'(!(strb && !m_wr[i])));
            chk($sformatf("dut%0d wr_n", i),  32'(o_wrn[i]), 32'(!(strb && m_wr[i])));
            chk($sformatf("dut%0d oe", i),    32'(o_oe[i]),  32'(act && m_wr[i]));
            chk($sformatf("dut%0d addr", i),  32'(o_addr[i]), 32'(m_addr[i]));
            chk($sformatf("dut%0d dout", i),  32'(o_dout[i]), 32'(m_dat[i]));
            chk($sformatf("dut%0d rdata", i), o_rdata[i], {16'd0, m_rd[i]});
            chk($sformatf("dut%0d waitreq", i), 32'(o_wait[i]), 32'(req && (o != tot(i))));
            chk($sformatf("dut%0d strobe overlap", i), 32'(o_rdn[i] | o_wrn[i]), 32'd1);
            if (o_cs[i]) hi_run[i]++;
            else begin
                if (hi_run[i] > 0) last_gap[i] = hi_run[i];
                hi_run[i] = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (din_rand) begin
            t_din[0] = 16'($urandom);
            t_din[1] = 16'($urandom);
        end
    end

    // Presents one access and leaves it asserted through the DONE cycle.
    task automatic do_access(input int i, input bit rd, input bit wr, input logic [1:0] a,
                             input logic [31:0] wd, output int lat, output int cs_lo,
                             output int wr_lo, output int rd_lo, output int oe_lo,
                             output logic [31:0] rdat, output logic [1:0] a_seen,
                             output logic [15:0] d_seen);
        bit seen;
        @(posedge clk); #1;
        t_cs[i] = 1'b1; t_rd[i] = rd; t_wr[i] = wr; t_addr[i] = a; t_wd[i] = wd;
        lat = -1; cs_lo = 0; wr_lo = 0; rd_lo = 0; oe_lo = 0; rdat = '0;
        a_seen = '0; d_seen = '0; seen = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (!o_cs[i]) begin
                cs_lo++;
                if (!seen) begin a_seen = o_addr[i]; d_seen = o_dout[i]; seen = 1'b1; end
            end
            if (!o_wrn[i]) wr_lo++;
            if (!o_rdn[i]) rd_lo++;
            if (o_oe[i])   oe_lo++;
            if (!o_wait[i]) begin
                lat = n; rdat = o_rdata[i];
                break;
            end
        end
        if (lat < 0) begin
            ntests++; nfail++;
            $display("FAIL dut%0d access timeout: waitrequest never dropped within 64 cycles", i);
        end
    endtask

    task automatic release_bus(input int i, input int n);
        @(posedge clk); #1;
        t_cs[i] = 1'b0; t_rd[i] = 1'b0; t_wr[i] = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic wait_idle(input int i);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (m_off[i] == 0) return;
        end
        ntests++; nfail++;
        $display("FAIL dut%0d idle timeout", i);
    endtask

    int          lat, cs_lo, wr_lo, rd_lo, oe_lo;
    logic [31:0] rdat;
    logic [1:0]  a_seen;
    logic [15:0] d_seen;

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            t_addr[i] = '0; t_cs[i] = 1'b0; t_rd[i] = 1'b0; t_wr[i] = 1'b0;
            t_wd[i] = '0; t_din[i] = '0;
        end
        repeat (3) @(posedge clk);
        #2;
        chk("reset cs_n",  32'(o_cs[0]),  32'd1);
        chk("reset rd_n",  32'(o_rdn[0]), 32'd1);
        chk("reset wr_n",  32'(o_wrn[0]), 32'd1);
        chk("reset oe",    32'(o_oe[0]),  32'd0);
        chk("reset addr",  32'(o_addr[0]), 32'd0);
        chk("reset dout",  32'(o_dout[0]), 32'd0);
        chk("reset rdata", o_rdata[0], 32'd0);
        @(negedge clk); reset_n = 1'b1;

        // write, address 2, 0x1234
        do_access(0, 1'b0, 1'b1, 2'd2, 32'h0000_1234, lat, cs_lo, wr_lo, rd_lo, oe_lo, rdat, a_seen, d_seen);
        chk("wr latency", 32'(lat), 32'd9);
        chk("wr cs_n low cycles", 32'(cs_lo), 32'd8);
        chk("wr wr_n low cycles", 32'(wr_lo), 32'd4);
        chk("wr rd_n low cycles", 32'(rd_lo), 32'd0);
        chk("wr oe cycles", 32'(oe_lo), 32'd8);
        chk("wr hpi_addr", 32'(a_seen), 32'd2);
        chk("wr hpi_data_out", 32'(d_seen), 32'h1234);
        release_bus(0, 2);

        // read, address 0, pad holds 0xBEEF
        t_din[0] = 16'hBEEF;
        do_access(0, 1'b1, 1'b0, 2'd0, 32'h0, lat, cs_lo, wr_lo, rd_lo, oe_lo, rdat, a_seen, d_seen);
        chk("rd latency", 32'(lat), 32'd9);
        chk("rd rd_n low cycles", 32'(rd_lo), 32'd4);
        chk("rd oe cycles", 32'(oe_lo), 32'd0);
        chk("rd readdata", rdat, 32'h0000_BEEF);
        release_bus(0, 2);

        // back-to-back write addr 1 then read addr 3
        do_access(0, 1'b0, 1'b1, 2'd1, 32'h0000_CAFE, lat, cs_lo, wr_lo, rd_lo, oe_lo, rdat, a_seen, d_seen);
        chk("b2b first wr_n cycles", 32'(wr_lo), 32'd4);
        t_din[0] = 16'h4321;
        do_access(0, 1'b1, 1'b0, 2'd3, 32'h0, lat, cs_lo, wr_lo, rd_lo, oe_lo, rdat, a_seen, d_seen);
        chk("b2b cs_n gap", 32'(last_gap[0]), 32'd2);
        chk("b2b second hpi_addr", 32'(a_seen), 32'd3);
        chk("b2b second latency", 32'(lat), 32'd9);
        chk("b2b second readdata", rdat, 32'h0000_4321);
        release_bus(0, 2);

        // reset during the second strobe cycle of a write
        @(posedge clk); #1;
        t_cs[0] = 1'b1; t_wr[0] = 1'b1; t_rd[0] = 1'b0; t_addr[0] = 2'd2; t_wd[0] = 32'h77;
        repeat (4) @(posedge clk);
        #1;
        chk("pre-reset wr_n", 32'(o_wrn[0]), 32'd0);
        chk("pre-reset oe", 32'(o_oe[0]), 32'd1);
        #1; reset_n = 1'b0;
        #1;
        chk("async reset wr_n", 32'(o_wrn[0]), 32'd1);
        chk("async reset cs_n", 32'(o_cs[0]), 32'd1);
        chk("async reset rd_n", 32'(o_rdn[0]), 32'd1);
        chk("async reset oe", 32'(o_oe[0]), 32'd0);
        chk("async reset addr", 32'(o_addr[0]), 32'd0);
        t_cs[0] = 1'b0; t_wr[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        t_din[0] = 16'h1357;
        do_access(0, 1'b1, 1'b0, 2'd1, 32'h0, lat, cs_lo, wr_lo, rd_lo, oe_lo, rdat, a_seen, d_seen);
        chk("post-reset rd latency", 32'(lat), 32'd9);
        chk("post-reset rd_n cycles", 32'(rd_lo), 32'd4);
        chk("post-reset readdata", rdat, 32'h0000_1357);
        release_bus(0, 2);

        // read and write both high: write wins
        do_access(0, 1'b1, 1'b1, 2'd0, 32'h0000_5A5A, lat, cs_lo, wr_lo, rd_lo, oe_lo, rdat, a_seen, d_seen);
        chk("both wr_n cycles", 32'(wr_lo), 32'd4);
        chk("both rd_n cycles", 32'(rd_lo), 32'd0);
        chk("both hpi_data_out", 32'(d_seen), 32'h5A5A);
        release_bus(0, 2);

        // minimum timing instance
        do_access(1, 1'b0, 1'b1, 2'd2, 32'h0000_00A5, lat, cs_lo, wr_lo, rd_lo, oe_lo, rdat, a_seen, d_seen);
        chk("min wr latency", 32'(lat), 32'd4);
        chk("min cs_n low cycles", 32'(cs_lo), 32'd3);
        chk("min wr_n low cycles", 32'(wr_lo), 32'd1);
        release_bus(1, 1);
        t_din[1] = 16'h0F0F;
        do_access(1, 1'b1, 1'b0, 2'd3, 32'h0, lat, cs_lo, wr_lo, rd_lo, oe_lo, rdat, a_seen, d_seen);
        chk("min rd latency", 32'(lat), 32'd4);
        chk("min rd_n low cycles", 32'(rd_lo), 32'd1);
        chk("min readdata", rdat, 32'h0000_0F0F);
        release_bus(1, 2);

        // randomized traffic on both instances, pad data changing every cycle
        din_rand = 1'b1;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 150; k++) begin
                int op;
                op = $urandom_range(0, 9);
                if (op == 0) begin
                    // read without chipselect: must not start a cycle
                    @(posedge clk); #1;
                    t_cs[i] = 1'b0; t_rd[i] = 1'b1; t_wr[i] = 1'($urandom_range(0, 1));
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    release_bus(i, 0);
                end else if (op == 1) begin
                    // request dropped mid-cycle
                    @(posedge clk); #1;
                    t_cs[i] = 1'b1; t_rd[i] = 1'b1; t_wr[i] = 1'($urandom_range(0, 1));
                    t_addr[i] = 2'($urandom_range(0, 3)); t_wd[i] = $urandom;
                    repeat ($urandom_range(1, 6)) @(posedge clk);
                    release_bus(i, 0);
                    wait_idle(i);
                end else begin
                    bit rd, wr;
                    rd = 1'($urandom_range(0, 1));
                    wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
                    do_access(i, rd, wr, 2'($urandom_range(0, 3)), $urandom,
                              lat, cs_lo, wr_lo, rd_lo, oe_lo, rdat, a_seen, d_seen);
                    if ($urandom_range(0, 1) == 1) release_bus(i, $urandom_range(0, 3));
                end
            end
            release_bus(i, 2);
            wait_idle(i);
        end
        din_rand = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
